// File: rtl/taxi_pkg.sv
// Shared definitions for the taxi fare meter: state encoding, BCD digit width
// and constant helpers used to size the binary counters.
package taxi_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/taxi_fare_meter_if.sv
// Control pulses/levels from the key and tick sources, and the packed BCD
// readout that goes to the display mux.
interface taxi_fare_meter_if #(
  parameter int FARE_DIGITS = 4,
  parameter int DIST_DIGITS = 4
);
  logic                     start;
  logic                     stop;
  logic                     clear;
  logic                     night;
  logic                     moving;
  logic                     dist_tick;
  logic                     sec_tick;
  logic [1:0]               state;
  logic [4*FARE_DIGITS-1:0] fare_bcd;
  logic [4*DIST_DIGITS-1:0] dist_bcd;
  logic [15:0]              wait_bcd;
  logic                     bcd_valid;

  modport master (
    output start, stop, clear, night, moving, dist_tick, sec_tick,
    input  state, fare_bcd, dist_bcd, wait_bcd, bcd_valid
  );

  modport slave (
    input  start, stop, clear, night, moving, dist_tick, sec_tick,
    output state, fare_bcd, dist_bcd, wait_bcd, bcd_valid
  );
endinterface

// File: rtl/taxi_fare_meter_bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, result loaded into
// bcd BIN_W+1 cycles after load; a new load restarts the conversion.
module bin2bcd_seq
  import taxi_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                      sys_clk,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic [DIGITS*BCD_W-1:0]   bcd
);

  localparam int CNT_W = clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W);

  logic [BIN_W-1:0]        sh;
  logic [DIGITS*BCD_W-1:0] acc;
  logic [DIGITS*BCD_W-1:0] acc_adj;
  logic [CNT_W-1:0]        cnt;

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[i*BCD_W +: BCD_W] >= 4'd5)
        acc_adj[i*BCD_W +: BCD_W] = acc[i*BCD_W +: BCD_W] + 4'd3;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      sh   <= '0;
      acc  <= '0;
      cnt  <= '0;
      bcd  <= '0;
    end else if (load) begin
      busy <= 1'b1;
      sh   <= bin;
      acc  <= '0;
      cnt  <= '0;
    end else if (busy) begin
      // Final cycle publishes the result; all others adjust-then-shift one bit.
      if (cnt == CNT_LAST) begin
        bcd  <= acc;
        busy <= 1'b0;
      end else begin
        {acc, sh} <= {acc_adj, sh} << 1;
        cnt       <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/taxi_fare_meter.sv
// Fare engine: trip FSM, saturating distance/fare/waiting counters and two
// sequential BCD converters feeding the display mux.
module taxi_fare_meter
  import taxi_pkg::*;
#(
  parameter int FARE_DIGITS = 4,
  parameter int DIST_DIGITS = 4,
  parameter int BASE_FARE   = 100,
  parameter int BASE_DIST   = 30,
  parameter int DAY_RATE    = 2,
  parameter int NIGHT_RATE  = 3,
  parameter int WAIT_SEC    = 60,
  parameter int WAIT_FARE   = 5
) (
  input logic               sys_clk,
  input logic               reset_n,
  taxi_fare_meter_if.slave  bus
);

  localparam int FARE_MAX = pow10(FARE_DIGITS) - 1;
  localparam int DIST_MAX = pow10(DIST_DIGITS) - 1;
  localparam int FARE_W   = clog2(FARE_MAX + 1);
  localparam int DIST_W   = clog2(DIST_MAX + 1);
  localparam int WSUB_W   = (WAIT_SEC > 2) ? clog2(WAIT_SEC) : 1;

  localparam logic [FARE_W-1:0] FARE_LIM   = FARE_W'(FARE_MAX);
  localparam logic [FARE_W-1:0] FARE_BASE  = FARE_W'(BASE_FARE);
  localparam logic [FARE_W-1:0] RATE_DAY   = FARE_W'(DAY_RATE);
  localparam logic [FARE_W-1:0] RATE_NIGHT = FARE_W'(NIGHT_RATE);
  localparam logic [FARE_W-1:0] WAIT_INC   = FARE_W'(WAIT_FARE);
  localparam logic [DIST_W-1:0] DIST_LIM   = DIST_W'(DIST_MAX);
  localparam logic [DIST_W-1:0] DIST_BASE  = DIST_W'(BASE_DIST);
  localparam logic [WSUB_W-1:0] WSUB_LAST  = WSUB_W'(WAIT_SEC - 1);

  state_t              state_q, state_d;
  logic                night_q, night_d;
  logic [FARE_W-1:0]   fare_q, fare_d;
  logic [DIST_W-1:0]   dist_q, dist_d;
  logic [WSUB_W-1:0]   wsub_q, wsub_d;
  logic [15:0]         wait_q, wait_d;
  logic                fare_upd_q, dist_upd_q;
  logic                fare_busy, dist_busy;
  logic [4*FARE_DIGITS-1:0] fare_bcd_w;
  logic [4*DIST_DIGITS-1:0] dist_bcd_w;

  logic                trip, count_en, dist_hit, wait_hit, dist_charge, wait_charge;
  logic [FARE_W-1:0]   rate, fare_inc;

  function automatic logic [FARE_W-1:0] sat_add(input logic [FARE_W-1:0] a,
                                                input logic [FARE_W-1:0] b);
    logic [FARE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, FARE_LIM}) ? FARE_LIM : s[FARE_W-1:0];
  endfunction

  // mm:ss digit counter, seconds wrap at 59, holds at 99:59.
  function automatic logic [15:0] wait_inc(input logic [15:0] w);
    logic [15:0] r;
    r = w;
    if (w != 16'h9959) begin
      if (w[3:0] != 4'd9) r[3:0] = w[3:0] + 4'd1;
      else begin
        r[3:0] = 4'd0;
        if (w[7:4] != 4'd5) r[7:4] = w[7:4] + 4'd1;
        else begin
          r[7:4] = 4'd0;
          if (w[11:8] != 4'd9) r[11:8] = w[11:8] + 4'd1;
          else begin
            r[11:8]  = 4'd0;
            r[15:12] = w[15:12] + 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

  assign trip        = (state_q == ST_RUN) || (state_q == ST_WAIT);
  assign count_en    = trip && !bus.clear && !bus.stop;
  assign dist_hit    = count_en && bus.dist_tick && (dist_q != DIST_LIM);
  assign dist_charge = dist_hit && (dist_q >= DIST_BASE);
  assign wait_hit    = count_en && bus.sec_tick && (state_q == ST_WAIT);
  assign wait_charge = wait_hit && (wsub_q == WSUB_LAST);
  assign rate        = night_q ? RATE_NIGHT : RATE_DAY;
  assign fare_inc    = (dist_charge ? rate : '0) + (wait_charge ? WAIT_INC : '0);

  always_comb begin
    state_d = state_q;
    night_d = night_q;
    fare_d  = fare_q;
    dist_d  = dist_q;
    wsub_d  = wsub_q;
    wait_d  = wait_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
      night_d = 1'b0;
      fare_d  = '0;
      dist_d  = '0;
      wsub_d  = '0;
      wait_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start && !bus.stop) begin
          state_d = ST_RUN;
          night_d = bus.night;
          fare_d  = FARE_BASE;
          dist_d  = '0;
          wsub_d  = '0;
          wait_d  = '0;
        end
        ST_RUN:  if (bus.stop) state_d = ST_DONE;
                 else if (!bus.moving) state_d = ST_WAIT;
        ST_WAIT: if (bus.stop) state_d = ST_DONE;
                 else if (bus.moving) state_d = ST_RUN;
        default: ;
      endcase
      if (count_en) begin
        if (dist_hit) dist_d = dist_q + DIST_W'(1);
        if (wait_hit) begin
          wait_d = wait_inc(wait_q);
          wsub_d = (wsub_q == WSUB_LAST) ? '0 : wsub_q + WSUB_W'(1);
        end
        fare_d = sat_add(fare_q, fare_inc);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      night_q    <= 1'b0;
      fare_q     <= '0;
      dist_q     <= '0;
      wsub_q     <= '0;
      wait_q     <= '0;
      fare_upd_q <= 1'b0;
      dist_upd_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      night_q    <= night_d;
      fare_q     <= fare_d;
      dist_q     <= dist_d;
      wsub_q     <= wsub_d;
      wait_q     <= wait_d;
      fare_upd_q <= (fare_d != fare_q);
      dist_upd_q <= (dist_d != dist_q);
    end
  end

  bin2bcd_seq #(.BIN_W(FARE_W), .DIGITS(FARE_DIGITS)) u_fare_bcd (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .load    (fare_upd_q),
    .bin     (fare_q),
    .busy    (fare_busy),
    .bcd     (fare_bcd_w)
  );

  bin2bcd_seq #(.BIN_W(DIST_W), .DIGITS(DIST_DIGITS)) u_dist_bcd (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .load    (dist_upd_q),
    .bin     (dist_q),
    .busy    (dist_busy),
    .bcd     (dist_bcd_w)
  );

  // A pending load counts as busy so valid drops the cycle after a change.
  assign bus.bcd_valid = !(fare_busy || dist_busy || fare_upd_q || dist_upd_q);
  assign bus.state     = state_q;
  assign bus.fare_bcd  = fare_bcd_w;
  assign bus.dist_bcd  = dist_bcd_w;
  assign bus.wait_bcd  = wait_q;

endmodule
